// File: rtl/buf_id_mgr.sv
// rtl/buf_id_mgr.sv - free-list manager handing out packet-buffer IDs and slot base addresses
module buf_id_mgr #(
  parameter int NUM_BUF    = 16,
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 11,
  parameter int SLOT_SHIFT = 7,
  parameter int LOW_WM     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_ack,
  output logic [ID_W-1:0]   alloc_id,
  output logic [ADDR_W-1:0] alloc_addr,
  input  logic              rel_valid,
  input  logic [ID_W-1:0]   rel_id,
  output logic              rel_err,
  output logic              init_done,
  output logic [ID_W:0]     free_count,
  output logic              low_wm
);

  localparam int PTR_W = $clog2(NUM_BUF);
  localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(NUM_BUF);
  localparam logic [ID_W:0] ONE      = (ID_W+1)'(1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state, state_next;
  logic [ID_W-1:0]         fifo [NUM_BUF];
  logic [PTR_W-1:0]        head, tail;
  logic [NUM_BUF-1:0]      in_use;
  logic                    grant, rel_ok, rel_in_range;
  logic [ID_W-1:0]         head_id;
  logic [ID_W+SLOT_SHIFT-1:0] head_addr_full;

  assign head_id        = fifo[head];
  assign head_addr_full = {head_id, {SLOT_SHIFT{1'b0}}};
  assign low_wm         = (free_count <= (ID_W+1)'(LOW_WM));

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_next;
  end

  // Grant is judged on the registered free_count, so a same-cycle release never bypasses an empty list.
  always_comb begin
    state_next   = state;
    grant        = 1'b0;
    rel_ok       = 1'b0;
    rel_in_range = ({1'b0, rel_id} < FULL_CNT);
    case (state)
      S_INIT: begin
        if (free_count == FULL_CNT) state_next = S_RUN;
      end
      S_RUN: begin
        grant  = alloc_req && (free_count != '0);
        rel_ok = rel_valid && rel_in_range && in_use[rel_id[PTR_W-1:0]];
      end
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ack  <= 1'b0;
      alloc_id   <= '0;
      alloc_addr <= '0;
      rel_err    <= 1'b0;
      init_done  <= 1'b0;
      free_count <= '0;
      in_use     <= '0;
      head       <= '0;
      tail       <= '0;
    end else begin
      alloc_ack <= grant;
      rel_err   <= rel_valid && !rel_ok;
      if (state == S_INIT) begin
        if (free_count != FULL_CNT) begin
          fifo[tail] <= ID_W'(tail);
          tail       <= tail + 1'b1;
          free_count <= free_count + ONE;
        end else begin
          init_done <= 1'b1;
        end
      end else begin
        if (grant) begin
          alloc_id                     <= head_id;
          alloc_addr                   <= ADDR_W'(head_addr_full);
          head                         <= head + 1'b1;
          in_use[head_id[PTR_W-1:0]]   <= 1'b1;
        end
        // A granted ID is never free at release time, so these two bitmap writes never collide.
        if (rel_ok) begin
          fifo[tail]                 <= rel_id;
          tail                       <= tail + 1'b1;
          in_use[rel_id[PTR_W-1:0]]  <= 1'b0;
        end
        case ({grant, rel_ok})
          2'b10:   free_count <= free_count - ONE;
          2'b01:   free_count <= free_count + ONE;
          default: free_count <= free_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buf_id_mgr.sv
// tb/tb_buf_id_mgr.sv - directed self-checking bench for buf_id_mgr
module tb_buf_id_mgr;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_req, rel_valid;
  logic [3:0]  rel_id;
  logic        alloc_ack, rel_err, init_done, low_wm;
  logic [3:0]  alloc_id;
  logic [10:0] alloc_addr;
  logic [4:0]  free_count;

  logic        b_alloc_req, b_rel_valid;
  logic [4:0]  b_rel_id;
  logic        b_alloc_ack, b_rel_err, b_init_done, b_low_wm;
  logic [4:0]  b_alloc_id;
  logic [10:0] b_alloc_addr;
  logic [5:0]  b_free_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  buf_id_mgr dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ack(alloc_ack),
    .alloc_id(alloc_id), .alloc_addr(alloc_addr), .rel_valid(rel_valid),
    .rel_id(rel_id), .rel_err(rel_err), .init_done(init_done),
    .free_count(free_count), .low_wm(low_wm)
  );

  buf_id_mgr #(.NUM_BUF(8), .ID_W(5), .ADDR_W(11), .SLOT_SHIFT(7), .LOW_WM(2)) dut_b (
    .clk(clk), .rst(rst), .alloc_req(b_alloc_req), .alloc_ack(b_alloc_ack),
    .alloc_id(b_alloc_id), .alloc_addr(b_alloc_addr), .rel_valid(b_rel_valid),
    .rel_id(b_rel_id), .rel_err(b_rel_err), .init_done(b_init_done),
    .free_count(b_free_count), .low_wm(b_low_wm)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_id(input logic [3:0] id, input logic exp_err);
    rel_valid = 1'b1;
    rel_id    = id;
    tick();
    check("rel_err", 32'(rel_err), 32'(exp_err));
    rel_valid = 1'b0;
  endtask

  task automatic grant_one(input int exp_id, input int exp_free);
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    check("ack", 32'(alloc_ack), 1);
    check("id", 32'(alloc_id), 32'(exp_id));
    check("addr", 32'(alloc_addr), 32'(exp_id * 128));
    check("free", 32'(free_count), 32'(exp_free));
  endtask

  task automatic run_init();
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("init_done", 32'(init_done), 32'(k == 17));
      check("init_noack", 32'(alloc_ack), 0);
      check("init_free", 32'(free_count), 32'((k > 16) ? 16 : k));
    end
  endtask

  initial begin
    rst = 1'b1; alloc_req = 1'b0; rel_valid = 1'b0; rel_id = '0;
    b_alloc_req = 1'b0; b_rel_valid = 1'b0; b_rel_id = '0;
    tick(); tick();
    check("rst_ack", 32'(alloc_ack), 0);
    check("rst_free", 32'(free_count), 0);
    check("rst_init", 32'(init_done), 0);
    check("rst_lowwm", 32'(low_wm), 1);
    check("rst_id", 32'(alloc_id), 0);
    check("rst_addr", 32'(alloc_addr), 0);

    // init with alloc_req held high, then full drain in order 0..15
    rst = 1'b0;
    alloc_req = 1'b1;
    run_init();
    for (int i = 0; i < 16; i++) begin
      tick();
      check("drain_ack", 32'(alloc_ack), 1);
      check("drain_id", 32'(alloc_id), 32'(i));
      check("drain_addr", 32'(alloc_addr), 32'(i * 128));
      check("drain_free", 32'(free_count), 32'(15 - i));
      check("drain_lowwm", 32'(low_wm), 32'((15 - i) <= 2));
    end
    tick();
    check("empty_noack", 32'(alloc_ack), 0);
    tick();
    check("empty_noack2", 32'(alloc_ack), 0);
    alloc_req = 1'b0;

    // FIFO reissue order follows release order
    release_id(4'd5, 1'b0);
    release_id(4'd2, 1'b0);
    release_id(4'd9, 1'b0);
    tick();
    check("free3", 32'(free_count), 3);
    grant_one(5, 2);
    grant_one(2, 1);
    grant_one(9, 0);
    tick();
    check("pulse_noack", 32'(alloc_ack), 0);

    // double free
    release_id(4'd3, 1'b0);
    release_id(4'd3, 1'b1);
    tick();
    check("dbl_err_clear", 32'(rel_err), 0);
    check("dbl_free", 32'(free_count), 1);

    // simultaneous alloc/release with free_count=4
    release_id(4'd4, 1'b0);
    release_id(4'd6, 1'b0);
    release_id(4'd7, 1'b0);
    alloc_req = 1'b1; rel_valid = 1'b1; rel_id = 4'd8;
    tick();
    alloc_req = 1'b0; rel_valid = 1'b0;
    check("sim_ack", 32'(alloc_ack), 1);
    check("sim_id", 32'(alloc_id), 3);
    check("sim_free", 32'(free_count), 4);
    check("sim_err", 32'(rel_err), 0);
    grant_one(4, 3);
    grant_one(6, 2);
    grant_one(7, 1);
    grant_one(8, 0);

    // simultaneous with free_count=0: no bypass
    alloc_req = 1'b1; rel_valid = 1'b1; rel_id = 4'd0;
    tick();
    rel_valid = 1'b0;
    check("nobyp_ack", 32'(alloc_ack), 0);
    check("nobyp_free", 32'(free_count), 1);
    check("nobyp_err", 32'(rel_err), 0);
    tick();
    alloc_req = 1'b0;
    check("nobyp_ack2", 32'(alloc_ack), 1);
    check("nobyp_id2", 32'(alloc_id), 0);
    check("nobyp_free2", 32'(free_count), 0);

    // releasing the ID being granted in the same cycle is rejected
    release_id(4'd1, 1'b0);
    alloc_req = 1'b1; rel_valid = 1'b1; rel_id = 4'd1;
    tick();
    alloc_req = 1'b0; rel_valid = 1'b0;
    check("same_ack", 32'(alloc_ack), 1);
    check("same_id", 32'(alloc_id), 1);
    check("same_err", 32'(rel_err), 1);
    check("same_free", 32'(free_count), 0);

    // mid-stream reset and re-init
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_ack", 32'(alloc_ack), 0);
    check("rr_free", 32'(free_count), 0);
    check("rr_init", 32'(init_done), 0);
    check("rr_id", 32'(alloc_id), 0);
    rel_valid = 1'b1; rel_id = 4'd2;
    tick();
    rel_valid = 1'b0;
    check("init_rel_err", 32'(rel_err), 1);
    for (int k = 2; k <= 17; k++) tick();
    check("rr_init_done", 32'(init_done), 1);
    check("rr_full", 32'(free_count), 16);
    grant_one(0, 15);
    grant_one(1, 14);
    grant_one(2, 13);
    release_id(4'd10, 1'b1);
    tick();
    check("stale_free", 32'(free_count), 13);

    // narrow instance: out-of-range and double-free release
    b_alloc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b_ack", 32'(b_alloc_ack), 1);
      check("b_id", 32'(b_alloc_id), 32'(i));
      check("b_addr", 32'(b_alloc_addr), 32'(i * 128));
    end
    b_alloc_req = 1'b0;
    b_rel_valid = 1'b1; b_rel_id = 5'd3;
    tick();
    check("b_rel3", 32'(b_rel_err), 0);
    tick();
    check("b_rel3_again", 32'(b_rel_err), 1);
    b_rel_id = 5'd16;
    tick();
    check("b_rel16", 32'(b_rel_err), 1);
    b_rel_valid = 1'b0;
    tick();
    check("b_err_clear", 32'(b_rel_err), 0);
    check("b_free", 32'(b_free_count), 5);
    check("b_noack", 32'(b_alloc_ack), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
